stream_mux: RTL and testbench

//  Parametrised N-channel, WIDTH-bit packet multiplexer with valid/ready handshake on every port.

---
 rtl/stream_mux.sv | 123 ++++++++++++
 tb/tb_stream_mux.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux.sv
// N-channel packet multiplexer with valid/ready on every port. The grant is
// chosen per packet (external sel or round-robin) and held until the last beat.
module stream_mux #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2,
  parameter int MODE  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH-1:0]       in_last,
  output logic [NCH-1:0]       in_ready,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      cur_ch,
  output logic                 busy
);

  typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [SELW-1:0]   rr_ptr;
  logic [SELW-1:0]   g;
  logic [SELW-1:0]   g_next;
  logic              found;
  logic              grant_valid;
  logic              can_take;
  logic              accept;
  logic              g_last;
  logic [WIDTH-1:0]  g_data;

  // Candidate channel: locked channel mid-packet, otherwise sel or round-robin.
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    g     = '0;
    found = 1'b0;
    if (state == PKT) begin
      g = cur_ch;
    end else if (MODE == 0) begin
      g = sel;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        for (int k = 0; k < NCH; k++) begin
          if (!found && in_valid[k] && (k == (int'(rr_ptr) + i) % NCH)) begin
            g     = SELW'(k);
            found = 1'b1;
          end
        end
      end
    end
  end

  // A select value outside 0..NCH-1 matches no channel, so nothing is granted.
  always_comb begin
    grant_valid = 1'b0;
    g_data      = '0;
    g_last      = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (g == SELW'(k)) begin
        grant_valid = in_valid[k];
        g_data      = in_data[k*WIDTH +: WIDTH];
        g_last      = in_last[k];
      end
    end
  end

  assign can_take = !out_valid || out_ready;
  assign accept   = grant_valid && can_take;
  assign g_next   = (g == SELW'(NCH - 1)) ? '0 : g + SELW'(1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = g_last ? IDLE : PKT;
    end
  end

  always_comb begin
    in_ready = '0;
    for (int k = 0; k < NCH; k++) begin
      if (g == SELW'(k)) begin
        in_ready[k] = accept;
      end
    end
    busy = (state == PKT);
  end

  // Output register stage; the round-robin pointer moves only on a last-beat accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      cur_ch    <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= g_data;
      out_last  <= g_last;
      cur_ch    <= g;
      if (g_last) begin
        rr_ptr <= g_next;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux.sv
// Bench for stream_mux: one fixed-select and one round-robin instance, checked
// every cycle against a packet-level model plus literal expectations per scenario.
module tb_stream_mux;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] in_data_b  [2];
  logic [3:0]  in_valid_b [2];
  logic [3:0]  in_last_b  [2];
  logic [3:0]  in_ready_b [2];
  logic [7:0]  out_data_b [2];
  logic        out_last_b [2];
  logic        out_valid_b[2];
  logic        out_ready_b[2];
  logic        busy_b     [2];
  logic [2:0]  sel0;
  logic [1:0]  sel1;
  logic [2:0]  cur_ch0;
  logic [1:0]  cur_ch1;

  stream_mux #(.WIDTH(8), .NCH(4), .SELW(3), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data_b[0]), .in_valid(in_valid_b[0]), .in_last(in_last_b[0]),
    .in_ready(in_ready_b[0]), .sel(sel0),
    .out_data(out_data_b[0]), .out_last(out_last_b[0]), .out_valid(out_valid_b[0]),
    .out_ready(out_ready_b[0]), .cur_ch(cur_ch0), .busy(busy_b[0])
  );

  stream_mux #(.WIDTH(8), .NCH(4), .SELW(2), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data_b[1]), .in_valid(in_valid_b[1]), .in_last(in_last_b[1]),
    .in_ready(in_ready_b[1]), .sel(sel1),
    .out_data(out_data_b[1]), .out_last(out_last_b[1]), .out_valid(out_valid_b[1]),
    .out_ready(out_ready_b[1]), .cur_ch(cur_ch1), .busy(busy_b[1])
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input int m, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, m, cyc, act, exp);
    end
  endtask

  // Packet-level model: lock = -1 when no packet is open, else the locked channel.
  int         lock [2];
  int         rr   [2];
  int         lch  [2];
  bit         ov   [2];
  bit         ol   [2];
  logic [7:0] od   [2];

  function automatic void model_grant(input int m, output int g, output bit gv);
    int s;
    g  = 0;
    gv = 1'b0;
    if (lock[m] >= 0) begin
      g  = lock[m];
      gv = in_valid_b[m][g];
    end else if (m == 0) begin
      s = int'(sel0);
      g = s;
      if (s < 4) gv = in_valid_b[0][s];
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!gv && in_valid_b[1][(rr[1] + i) % 4]) begin
          g  = (rr[1] + i) % 4;
          gv = 1'b1;
        end
      end
    end
  endfunction

  function automatic logic [3:0] model_ready(input int m);
    int g;
    bit gv;
    model_grant(m, g, gv);
    return (gv && (!ov[m] || out_ready_b[m])) ? 4'(1 << g) : 4'b0000;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        lock[m] = -1; rr[m] = 0; lch[m] = 0; ov[m] = 0; ol[m] = 0; od[m] = '0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        int g;
        bit gv;
        model_grant(m, g, gv);
        if (gv && (!ov[m] || out_ready_b[m])) begin
          ov[m]  = 1'b1;
          od[m]  = in_data_b[m][g*8 +: 8];
          ol[m]  = in_last_b[m][g];
          lch[m] = g;
          if (ol[m]) begin
            lock[m] = -1;
            rr[m]   = (g + 1) % 4;
          end else begin
            lock[m] = g;
          end
        end else if (out_ready_b[m]) begin
          ov[m] = 1'b0;
        end
      end
    end
  end

  // Output log of delivered beats {last, data} with the cycle they left.
  logic [8:0] lg [2][32];
  int         lc [2][32];
  int         ln [2];

  always @(negedge clk) begin
    if (rst_n) begin
      for (int m = 0; m < 2; m++) begin
        check("out_valid", m, out_valid_b[m], ov[m]);
        check("out_data", m, out_data_b[m], od[m]);
        check("out_last", m, out_last_b[m], ol[m]);
        check("cur_ch", m, (m == 0) ? cur_ch0 : {1'b0, cur_ch1}, lch[m]);
        check("busy", m, busy_b[m], lock[m] >= 0);
        check("in_ready", m, in_ready_b[m], model_ready(m));
        if (out_valid_b[m] && out_ready_b[m] && ln[m] < 32) begin
          lg[m][ln[m]] = {out_last_b[m], out_data_b[m]};
          lc[m][ln[m]] = cyc;
          ln[m]++;
        end
      end
    end
  end

  // Producers: per-channel beat queues, advanced on observed handshakes.
  logic [8:0] pm  [2][4][16];
  int         hd  [2][4];
  int         tl  [2][4];
  bit         gap [2][4];

  task automatic refresh();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 4; k++) begin
        if (hd[m][k] < tl[m][k] && !gap[m][k]) begin
          in_valid_b[m][k]       = 1'b1;
          in_last_b[m][k]        = pm[m][k][hd[m][k]][8];
          in_data_b[m][k*8 +: 8] = pm[m][k][hd[m][k]][7:0];
        end else begin
          in_valid_b[m][k]       = 1'b0;
          in_last_b[m][k]        = 1'b0;
          in_data_b[m][k*8 +: 8] = 8'h00;
        end
      end
    end
  endtask

  task automatic clear_all();
    for (int m = 0; m < 2; m++) begin
      ln[m] = 0;
      for (int k = 0; k < 4; k++) begin
        hd[m][k] = 0; tl[m][k] = 0; gap[m][k] = 1'b0;
      end
    end
    refresh();
  endtask

  task automatic push(input int m, input int k, input logic last, input logic [7:0] d);
    pm[m][k][tl[m][k]] = {last, d};
    tl[m][k]++;
  endtask

  task automatic step();
    logic [3:0] hs [2];
    @(negedge clk);
    for (int m = 0; m < 2; m++) hs[m] = in_valid_b[m] & in_ready_b[m];
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < 4; k++)
        if (hs[m][k]) hd[m][k]++;
    refresh();
  endtask

  function automatic bit pending(input int m);
    bit p = 1'b0;
    for (int k = 0; k < 4; k++) if (hd[m][k] < tl[m][k]) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input int m);
    int n = 0;
    while (n < 60 && (pending(m) || out_valid_b[m])) begin
      step();
      n++;
    end
    check("drain_bound", m, n < 60, 1);
  endtask

  task automatic chk_log(input int m, input int idx, input logic [8:0] exp);
    check("log_beat", m, (idx < ln[m]) ? {23'b0, lg[m][idx]} : 32'hdead, {23'b0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int m = 0; m < 2; m++) out_ready_b[m] = 1'b1;
    sel0 = 3'd0;
    sel1 = 2'd0;
    clear_all();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      check("rst_out_valid", m, out_valid_b[m], 0);
      check("rst_out_data", m, out_data_b[m], 0);
      check("rst_out_last", m, out_last_b[m], 0);
      check("rst_busy", m, busy_b[m], 0);
    end
    check("rst_cur_ch", 0, cur_ch0, 0);
    check("rst_cur_ch", 1, cur_ch1, 0);
    rst_n = 1'b1;
    step();

    // Fixed select: three-beat packet from channel 2 at full rate
    clear_all();
    sel0 = 3'd2;
    push(0, 2, 0, 8'hA1); push(0, 2, 0, 8'hA2); push(0, 2, 1, 8'hA3);
    refresh();
    drain(0);
    chk_log(0, 0, 9'h0A1);
    chk_log(0, 1, 9'h0A2);
    chk_log(0, 2, 9'h1A3);
    check("a_back_to_back", 0, lc[0][1] - lc[0][0], 1);
    check("a_back_to_back", 0, lc[0][2] - lc[0][0], 2);

    // sel moves 2 -> 0 after the first beat: channel 2 keeps the lock to its last beat
    clear_all();
    sel0 = 3'd2;
    push(0, 2, 0, 8'hB1); push(0, 2, 0, 8'hB2); push(0, 2, 0, 8'hB3); push(0, 2, 1, 8'hB4);
    push(0, 0, 1, 8'hC0);
    refresh();
    step();
    sel0 = 3'd0;
    #1;
    check("b_busy_locked", 0, busy_b[0], 1);
    check("b_cur_ch", 0, cur_ch0, 2);
    check("b_ready_ch2", 0, in_ready_b[0], 4'b0100);
    drain(0);
    chk_log(0, 0, 9'h0B1);
    chk_log(0, 1, 9'h0B2);
    chk_log(0, 2, 9'h0B3);
    chk_log(0, 3, 9'h1B4);
    chk_log(0, 4, 9'h1C0);

    // Round-robin: single-beat packets on all channels, order 0,1,2,3 then wrap to 0
    clear_all();
    for (int k = 0; k < 4; k++) push(1, k, 1, 8'(8'h30 + k));
    push(1, 0, 1, 8'h40);
    refresh();
    drain(1);
    chk_log(1, 0, 9'h130);
    chk_log(1, 1, 9'h131);
    chk_log(1, 2, 9'h132);
    chk_log(1, 3, 9'h133);
    chk_log(1, 4, 9'h140);

    // Backpressure for 3 cycles, then an idle gap inside the packet with ch0 waiting
    clear_all();
    push(1, 1, 0, 8'hE1); push(1, 1, 0, 8'hE2); push(1, 1, 0, 8'hE3); push(1, 1, 1, 8'hE4);
    push(1, 0, 1, 8'h50);
    refresh();
    step();
    step();
    out_ready_b[1] = 1'b0;
    #1;
    check("stall_ready", 1, in_ready_b[1], 4'b0000);
    repeat (3) step();
    out_ready_b[1] = 1'b1;
    gap[1][1] = 1'b1;
    refresh();
    #1;
    check("gap_ready", 1, in_ready_b[1], 4'b0000);
    check("gap_busy", 1, busy_b[1], 1);
    step();
    step();
    gap[1][1] = 1'b0;
    refresh();
    drain(1);
    chk_log(1, 0, 9'h0E1);
    chk_log(1, 1, 9'h0E2);
    chk_log(1, 2, 9'h0E3);
    chk_log(1, 3, 9'h1E4);
    chk_log(1, 4, 9'h150);
    check("e_beat_count", 1, ln[1], 5);

    // Reset during beat 2 of a packet: truncation, then arbitration restarts at channel 0
    clear_all();
    push(1, 3, 0, 8'hF1); push(1, 3, 0, 8'hF2); push(1, 3, 0, 8'hF3); push(1, 3, 1, 8'hF4);
    refresh();
    step();
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 1, out_valid_b[1], 0);
    check("rst_mid_busy", 1, busy_b[1], 0);
    check("rst_mid_cur_ch", 1, cur_ch1, 0);
    clear_all();
    step();
    rst_n = 1'b1;
    push(1, 0, 1, 8'h70);
    push(1, 3, 1, 8'h73);
    refresh();
    drain(1);
    chk_log(1, 0, 9'h170);
    chk_log(1, 1, 9'h173);

    // Out-of-range select: nothing granted although every channel is valid
    clear_all();
    sel0 = 3'd5;
    for (int k = 0; k < 4; k++) push(0, k, 1, 8'(8'h60 + k));
    refresh();
    repeat (3) begin
      #1;
      check("sel5_ready", 0, in_ready_b[0], 4'b0000);
      check("sel5_out_valid", 0, out_valid_b[0], 0);
      step();
    end
    clear_all();
    sel0 = 3'd0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
